// File: rtl/scumvcontroller_response_arbiter.sv
// Response arbiter for the host-bound byte stream.
// Three sources (ASC, STL, status/telemetry) share one outgoing byte stream.
// Whole packets are granted in round-robin order. Each packet is preceded by
// a one-byte source tag. A stall watchdog aborts a packet whose source stops
// supplying bytes mid-packet and emits ABORT_BYTE in its place.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   src_valid/ready   per-source byte handshake (bit0=ASC, bit1=STL, bit2=status)
//   src_data          per-source byte, [8i+7:8i] belongs to source i
//   src_last          per-source end-of-packet flag
//   out_valid/ready   handshake toward the outgoing FIFO
//   out_data          byte toward the outgoing FIFO
//   grant             current owner 0/1/2, 3 = none
//   busy              high whenever the arbiter is not idle
//   timeout_count     saturating count of aborted packets
//
// state  | meaning
// IDLE   | no owner; pick next requester round-robin
// HEADER | emit the source tag of the granted source
// DATA   | forward bytes of the granted source until src_last
// ABORT  | source stalled too long; emit ABORT_BYTE and release
module scumvcontroller_response_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter logic [7:0]  TAG_ASC        = 8'h41,
    parameter logic [7:0]  TAG_STL        = 8'h53,
    parameter logic [7:0]  TAG_STS        = 8'h54,
    parameter logic [7:0]  ABORT_BYTE     = 8'hEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  src_valid,
    output logic [2:0]  src_ready,
    input  logic [23:0] src_data,
    input  logic [2:0]  src_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic [23:0] STALL_LIMIT = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  NO_GRANT    = 2'd3;

    state_t      state, state_next;
    logic [1:0]  grant_next;
    logic [1:0]  last_grant, last_grant_next;
    logic [23:0] stall_cnt, stall_cnt_next;
    logic [7:0]  timeout_count_next;

    // Padded to 4 entries so a 2-bit grant can index them directly.
    logic [3:0]  req;
    logic [3:0]  ready_vec;

    logic [1:0]  cand0, cand1, cand2;
    logic [1:0]  rr_pick;

    logic        grant_valid;
    logic        grant_last;
    logic [7:0]  grant_byte;
    logic [7:0]  tag_byte;

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return (g >= 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    assign req   = {1'b0, src_valid};
    assign cand0 = rr_next(last_grant);
    assign cand1 = rr_next(cand0);
    assign cand2 = rr_next(cand1);

    always_comb begin
        rr_pick = NO_GRANT;
        if (req[cand0])      rr_pick = cand0;
        else if (req[cand1]) rr_pick = cand1;
        else if (req[cand2]) rr_pick = cand2;
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        grant_byte  = 8'h00;
        tag_byte    = 8'h00;
        case (grant)
            2'd0: begin
                grant_valid = src_valid[0];
                grant_last  = src_last[0];
                grant_byte  = src_data[7:0];
                tag_byte    = TAG_ASC;
            end
            2'd1: begin
                grant_valid = src_valid[1];
                grant_last  = src_last[1];
                grant_byte  = src_data[15:8];
                tag_byte    = TAG_STL;
            end
            2'd2: begin
                grant_valid = src_valid[2];
                grant_last  = src_last[2];
                grant_byte  = src_data[23:16];
                tag_byte    = TAG_STS;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next         = state;
        grant_next         = grant;
        last_grant_next    = last_grant;
        stall_cnt_next     = stall_cnt;
        timeout_count_next = timeout_count;
        out_valid          = 1'b0;
        out_data           = 8'h00;
        ready_vec          = 4'b0000;
        case (state)
            IDLE: begin
                if (|src_valid) begin
                    grant_next = rr_pick;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                out_valid = 1'b1;
                out_data  = tag_byte;
                if (out_ready) begin
                    stall_cnt_next = '0;
                    state_next     = DATA;
                end
            end
            DATA: begin
                out_valid        = grant_valid;
                out_data         = grant_byte;
                ready_vec[grant] = out_ready;
                if (grant_valid && out_ready) begin
                    stall_cnt_next = '0;
                    if (grant_last) begin
                        last_grant_next = grant;
                        grant_next      = NO_GRANT;
                        state_next      = IDLE;
                    end
                end else if (!grant_valid) begin
                    // Backpressure (valid but not ready) leaves the counter alone.
                    if (stall_cnt >= STALL_LIMIT) begin
                        state_next = ABORT;
                    end else begin
                        stall_cnt_next = stall_cnt + 24'd1;
                    end
                end
            end
            ABORT: begin
                out_valid = 1'b1;
                out_data  = ABORT_BYTE;
                if (out_ready) begin
                    if (timeout_count != 8'hFF) begin
                        timeout_count_next = timeout_count + 8'd1;
                    end
                    last_grant_next = grant;
                    grant_next      = NO_GRANT;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign src_ready = ready_vec[2:0];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= NO_GRANT;
            last_grant    <= 2'd2;
            stall_cnt     <= '0;
            timeout_count <= 8'h00;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            last_grant    <= last_grant_next;
            stall_cnt     <= stall_cnt_next;
            timeout_count <= timeout_count_next;
        end
    end

endmodule

// File: doc/scumvcontroller_response_arbiter.md
Name: scumvcontroller_response_arbiter

Overview:
- Shares the single host-bound response byte stream (outgoing FIFO → UART TX) among three sources: ASC response, STL response and controller status/telemetry.
- Grants whole packets only, using round-robin order. Each packet is prefixed with a one-byte source tag so the host can demultiplex.
- A per-packet stall watchdog aborts a packet whose source stops supplying bytes mid-packet, so a hung subsystem cannot block the host link.

Parameters:
- TIMEOUT_CYCLES, 100_000, consecutive source-stall cycles in DATA before abort (1 ms at 100 MHz); legal range 2..2^24-1.
- TAG_ASC, 8'h41, header byte for source 0 (ASC).
- TAG_STL, 8'h53, header byte for source 1 (STL).
- TAG_STS, 8'h54, header byte for source 2 (status).
- ABORT_BYTE, 8'hEE, byte emitted when a packet is aborted.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- src_valid  input  3  per-source byte valid; bit0=ASC, bit1=STL, bit2=status.
- src_ready  output  3  per-source byte accept.
- src_data  input  24  per-source byte; [8i+7:8i] belongs to source i.
- src_last  input  3  per-source flag marking the final byte of a packet.
- out_valid  output  1  byte available to the outgoing FIFO.
- out_ready  input  1  outgoing FIFO not full.
- out_data  output  8  byte to the outgoing FIFO.
- grant  output  2  current owner 0/1/2; 3 = none.
- busy  output  1  high in any state other than IDLE.
- timeout_count  output  8  saturating count of aborted packets.

Behaviour:
- Reset (async, active-high) drives the following values:
  - state=IDLE, grant=3, last_grant=2 (so source 0 has first priority), busy=0, timeout_count=0, stall counter=0.
  - out_valid, src_ready and out_data are all 0 while in reset.
- Reset asserted mid-packet returns to IDLE immediately. A partially sent packet is not completed; the host resynchronises on the next tag.
- A transfer occurs on a clock edge where valid&&ready. out_valid, out_data and src_ready are combinational from state and inputs.
- State IDLE:
  - out_valid=0, src_ready=0.
  - If any src_valid bit is set, register grant = the first set bit searching upward from (last_grant+1) mod 3, then go to HEADER.
  - Arbitration takes one cycle; no bytes are consumed from sources in IDLE.
- State HEADER:
  - out_valid=1, out_data=tag of the granted source, src_ready=0.
  - On out_ready: clear the stall counter and go to DATA.
- State DATA:
  - out_valid=src_valid[grant], out_data=src byte of grant, src_ready[grant]=out_ready; all other src_ready bits are 0.
  - On a transfer with src_last[grant]=1: last_grant<=grant, grant<=3, go to IDLE.
  - On any transfer: clear the stall counter.
  - If src_valid[grant]=0: increment the stall counter. When it reaches TIMEOUT_CYCLES-1 while still stalled, go to ABORT.
  - out_ready=0 with src_valid=1 is backpressure, not a stall: the counter holds its value.
- State ABORT:
  - out_valid=1, out_data=ABORT_BYTE, all src_ready=0.
  - On out_ready: timeout_count += 1, saturating at 255; last_grant<=grant; grant<=3; go to IDLE.
- After an abort, any remaining bytes from that source are sent as a new tagged packet at its next grant; the host discards them.
- Packet length is unbounded. A source asserting src_last on the first DATA byte sends a 2-byte packet (tag + 1 byte).
- Simultaneous requests resolve in round-robin order. A source whose valid drops while in IDLE before the grant is registered is simply not chosen.
- Per-packet overhead is 1 tag byte plus 1 arbitration cycle. Back-to-back packets have a 1-cycle IDLE gap.
- State encoding is 2 bits: IDLE=0, HEADER=1, DATA=2, ABORT=3.

Test Plan:
- ASC only: 1-byte packet 0x07 with last, out_ready=1 → out stream 0x41, 0x07; grant returns to 3; busy goes 1 then 0.
- STL 16-byte packet 0x00..0x0F with out_ready toggling every cycle → out 0x53 then 0x00..0x0F in order, no byte lost or duplicated; src_ready[1] tracks out_ready.
- All three sources valid continuously with 2-byte packets → packet tag order 0x41, 0x53, 0x54, 0x41, …; no source starves.
- Fairness with two sources: after an STL packet completes while ASC and STL both request → ASC is granted next.
- Timeout: TIMEOUT_CYCLES=8; STL sends 3 bytes then deasserts valid → after 8 stall cycles output 0xEE; timeout_count=1; a pending ASC packet is served next.
- Backpressure: out_ready=0 for 1000 cycles mid-DATA with src valid → no abort; timeout_count stays 0. Assert reset during DATA → outputs go to reset values asynchronously, and the next packet starts with a tag.
